// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer
// Records every architectural register write leaving WriteBack as {pc, regId, data, seq}
// in a first-word-fall-through FIFO. A valid/ready debug port drains the FIFO. The block
// also counts and flags commits that are dropped because the FIFO is full.
module retire_trace_buffer #(
    parameter int DEPTH     = 16,
    parameter int SEQ_W     = 16,
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     traceEnable,
    input  logic                     wbWriteEnable,
    input  logic [4:0]               wbRegId,
    input  logic [31:0]              wbData,
    input  logic [31:0]              wbPc,
    output logic                     traceValid,
    input  logic                     traceReady,
    output logic [31:0]              tracePc,
    output logic [4:0]               traceRegId,
    output logic [31:0]              traceData,
    output logic [SEQ_W-1:0]         traceSeq,
    output logic                     almostFull,
    output logic                     overflow,
    output logic [15:0]              dropCount,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    // almostFull asserts at this occupancy, so a debug stall has two entries of slack
    localparam logic [PTR_W:0] AF_LEVEL = (PTR_W + 1)'(DEPTH - 2);

    // Pointers carry one extra wrap bit so full and empty can be told apart
    logic [PTR_W:0]   wrPtr;
    logic [PTR_W:0]   rdPtr;
    logic [PTR_W:0]   occCount;
    logic [PTR_W:0]   occNext;
    logic [SEQ_W-1:0] seqCount;
    logic             almostFullReg;
    logic             overflowReg;
    logic [15:0]      dropReg;

    // Record storage; no reset needed because outputs are gated by traceValid
    logic [31:0]      memPc   [DEPTH];
    logic [4:0]       memReg  [DEPTH];
    logic [31:0]      memData [DEPTH];
    logic [SEQ_W-1:0] memSeq  [DEPTH];

    logic             isEmpty;
    logic             isFull;
    logic             commit;
    logic             doPop;
    logic             doPush;
    logic             doDrop;
    logic [PTR_W-1:0] wrIdx;
    logic [PTR_W-1:0] rdIdx;

    assign wrIdx = wrPtr[PTR_W-1:0];
    assign rdIdx = rdPtr[PTR_W-1:0];

    // Qualify the WriteBack strobe and decide push / pop / drop for this edge
    always_comb begin
        isEmpty = (wrPtr == rdPtr);
        isFull  = (wrPtr[PTR_W] != rdPtr[PTR_W]) && (wrIdx == rdIdx);
        commit  = traceEnable && wbWriteEnable && !(SKIP_ZERO && (wbRegId == 5'd0));
        doPop   = !isEmpty && traceReady;
        // A full FIFO still accepts when the head leaves on the same edge
        doPush  = commit && (!isFull || doPop);
        doDrop  = commit && isFull && !doPop;
        occNext = occCount + {{PTR_W{1'b0}}, doPush} - {{PTR_W{1'b0}}, doPop};
    end

    // Pointer, occupancy and almost-full registers; clear wins over push and pop
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr         <= '0;
            rdPtr         <= '0;
            occCount      <= '0;
            almostFullReg <= 1'b0;
        end else if (clear) begin
            wrPtr         <= '0;
            rdPtr         <= '0;
            occCount      <= '0;
            almostFullReg <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            occCount      <= occNext;
            almostFullReg <= (occNext >= AF_LEVEL);
        end
    end

    // Sequence numbers advance on every commit, stored or dropped, so gaps expose drops
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seqCount <= '0;
        end else if (clear) begin
            seqCount <= '0;
        end else if (commit) begin
            seqCount <= seqCount + 1'b1;
        end
    end

    // Drop accounting: sticky overflow flag and a saturating drop counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflowReg <= 1'b0;
            dropReg     <= '0;
        end else if (clear) begin
            overflowReg <= 1'b0;
            dropReg     <= '0;
        end else if (doDrop) begin
            overflowReg <= 1'b1;
            if (dropReg != 16'hFFFF) begin
                dropReg <= dropReg + 16'd1;
            end
        end
    end

    // Record write at the tail; the entry becomes visible once wrPtr moves past it
    always_ff @(posedge clock) begin
        if (doPush && !clear) begin
            memPc[wrIdx]   <= wbPc;
            memReg[wrIdx]  <= wbRegId;
            memData[wrIdx] <= wbData;
            memSeq[wrIdx]  <= seqCount;
        end
    end

    // Head entry is presented directly; outputs read as zero while the FIFO is empty
    always_comb begin
        traceValid = !isEmpty;
        tracePc    = '0;
        traceRegId = '0;
        traceData  = '0;
        traceSeq   = '0;
        if (traceValid) begin
            tracePc    = memPc[rdIdx];
            traceRegId = memReg[rdIdx];
            traceData  = memData[rdIdx];
            traceSeq   = memSeq[rdIdx];
        end
    end

    assign almostFull = almostFullReg;
    assign overflow   = overflowReg;
    assign dropCount  = dropReg;
    assign occupancy  = occCount;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Self-checking bench for retire_trace_buffer: directed scenarios plus random traffic,
// all compared against a queue-based reference model of the trace FIFO.
module tb_retire_trace_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        clear;
    logic        traceEnable;
    logic        wbWriteEnable;
    logic [4:0]  wbRegId;
    logic [31:0] wbData;
    logic [31:0] wbPc;
    logic        traceValid;
    logic        traceReady;
    logic [31:0] tracePc;
    logic [4:0]  traceRegId;
    logic [31:0] traceData;
    logic [15:0] traceSeq;
    logic        almostFull;
    logic        overflow;
    logic [15:0] dropCount;
    logic [4:0]  occupancy;

    retire_trace_buffer #(.DEPTH(16), .SEQ_W(16), .SKIP_ZERO(1'b1)) dut (
        .clock(clock), .reset(reset), .clear(clear), .traceEnable(traceEnable),
        .wbWriteEnable(wbWriteEnable), .wbRegId(wbRegId), .wbData(wbData), .wbPc(wbPc),
        .traceValid(traceValid), .traceReady(traceReady), .tracePc(tracePc),
        .traceRegId(traceRegId), .traceData(traceData), .traceSeq(traceSeq),
        .almostFull(almostFull), .overflow(overflow), .dropCount(dropCount),
        .occupancy(occupancy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rid;
        logic [31:0] data;
        logic [15:0] seq;
    } rec_t;

    rec_t        q[$];
    logic [15:0] mSeq;
    logic [15:0] mDrops;
    logic        mOvf;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        q.delete();
        mSeq   = '0;
        mDrops = '0;
        mOvf   = 1'b0;
    endtask

    // One clock edge of the reference: a record list with capacity 16
    task automatic modelStep();
        bit   isCommit;
        bit   pop;
        bit   full;
        rec_t r;
        isCommit = traceEnable && wbWriteEnable && (wbRegId != 5'd0);
        if (clear) begin
            modelReset();
            return;
        end
        pop  = (q.size() > 0) && traceReady;
        full = (q.size() == 16);
        if (pop) void'(q.pop_front());
        if (isCommit) begin
            if (!full || pop) begin
                r.pc = wbPc; r.rid = wbRegId; r.data = wbData; r.seq = mSeq;
                q.push_back(r);
            end else begin
                mOvf = 1'b1;
                if (mDrops != 16'hFFFF) mDrops = mDrops + 16'd1;
            end
            mSeq = mSeq + 16'd1;
        end
    endtask

    task automatic checkAll(input string tag);
        rec_t h;
        h = '{pc: 32'd0, rid: 5'd0, data: 32'd0, seq: 16'd0};
        if (q.size() > 0) h = q[0];
        chk({tag, ".valid"}, 32'(traceValid), 32'(q.size() > 0));
        chk({tag, ".occ"},   32'(occupancy),  32'(q.size()));
        chk({tag, ".af"},    32'(almostFull), 32'(q.size() >= 14));
        chk({tag, ".ovf"},   32'(overflow),   32'(mOvf));
        chk({tag, ".drops"}, 32'(dropCount),  32'(mDrops));
        chk({tag, ".pc"},    tracePc,         h.pc);
        chk({tag, ".rid"},   32'(traceRegId), 32'(h.rid));
        chk({tag, ".data"},  traceData,       h.data);
        chk({tag, ".seq"},   32'(traceSeq),   32'(h.seq));
    endtask

    // Inputs are changed only at the falling edge
    task automatic drive(input bit en, input bit we, input logic [4:0] rid,
                         input logic [31:0] d, input logic [31:0] pc,
                         input bit rdy, input bit clr);
        traceEnable = en; wbWriteEnable = we; wbRegId = rid;
        wbData = d; wbPc = pc; traceReady = rdy; clear = clr;
    endtask

    task automatic cycle(input string tag);
        @(posedge clock);
        modelStep();
        @(negedge clock);
        checkAll(tag);
    endtask

    task automatic idle(input bit rdy);
        drive(1, 0, 5'd0, 32'd0, 32'd0, rdy, 0);
    endtask

    task automatic commitOne(input logic [4:0] rid, input bit rdy);
        drive(1, 1, rid, $urandom, $urandom, rdy, 0);
    endtask

    initial begin
        modelReset();
        reset = 1'b0;
        idle(0);
        #3;
        checkAll("reset");
        @(negedge clock);
        reset = 1'b1;

        // 1: single commit then pop
        drive(1, 1, 5'd8, 32'h0000_00AA, 32'h0040_0000, 0, 0);
        cycle("t1.push");
        chk("t1.seq0", 32'(traceSeq), 32'd0);
        chk("t1.rid8", 32'(traceRegId), 32'd8);
        idle(1);
        cycle("t1.pop");
        chk("t1.empty", 32'(traceValid), 32'd0);

        // 2: register 0 is skipped and does not consume a sequence number
        drive(1, 0, 5'd0, 0, 0, 0, 1);
        cycle("t2.clr");
        drive(1, 1, 5'd0, 32'h1111, 32'h100, 0, 0);
        cycle("t2.r0");
        drive(1, 1, 5'd3, 32'h3333, 32'h104, 0, 0);
        cycle("t2.r3");
        chk("t2.seq", 32'(traceSeq), 32'd0);
        chk("t2.rid", 32'(traceRegId), 32'd3);
        chk("t2.occ", 32'(occupancy), 32'd1);

        // 3: overfill with consumer stalled, then drain in order
        drive(1, 0, 5'd0, 0, 0, 0, 1);
        cycle("t3.clr");
        for (int i = 0; i < 18; i++) begin
            commitOne(5'(1 + (i % 31)), 0);
            cycle("t3.fill");
        end
        chk("t3.occ16", 32'(occupancy), 32'd16);
        chk("t3.drop2", 32'(dropCount), 32'd2);
        chk("t3.ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk("t3.order", 32'(traceSeq), 32'(i));
            idle(1);
            cycle("t3.drain");
        end
        commitOne(5'd7, 0);
        cycle("t3.next");
        chk("t3.seq18", 32'(traceSeq), 32'd18);

        // 4: full FIFO with simultaneous commit and pop
        for (int i = 0; i < 15; i++) begin
            commitOne(5'd9, 0);
            cycle("t4.fill");
        end
        commitOne(5'd10, 1);
        cycle("t4.both");
        chk("t4.occ16", 32'(occupancy), 32'd16);
        chk("t4.drops", 32'(dropCount), 32'd2);
        chk("t4.tail", 32'(q[15].seq), 32'd34);

        // 5: interleaved pushes and pops with the consumer toggling, then random traffic
        for (int i = 0; i < 20; i++) begin
            commitOne(5'(1 + $urandom_range(0, 30)), bit'(i % 2));
            cycle("t5.toggle");
        end
        for (int i = 0; i < 120; i++) begin
            drive(bit'($urandom_range(0, 7) != 0), bit'($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 31)), $urandom, $urandom,
                  bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 40) == 0));
            cycle("t5.rand");
        end

        // 6: clear with a commit in the same cycle while holding five entries
        for (int i = 0; i < 20; i++) begin
            idle(1);
            cycle("t6.drain");
        end
        // Force a drop so the clear has a sticky flag to reset
        for (int i = 0; i < 17; i++) begin
            commitOne(5'd4, 0);
            cycle("t6.over");
        end
        chk("t6.ovfset", 32'(overflow), 32'd1);
        for (int i = 0; i < 11; i++) begin
            idle(1);
            cycle("t6.down");
        end
        chk("t6.occ5", 32'(occupancy), 32'd5);
        drive(1, 1, 5'd6, 32'hDEAD, 32'hBEEF, 0, 1);
        cycle("t6.clr");
        chk("t6.occ0", 32'(occupancy), 32'd0);
        chk("t6.ovf0", 32'(overflow), 32'd0);
        chk("t6.valid0", 32'(traceValid), 32'd0);
        commitOne(5'd6, 0);
        cycle("t6.after");
        chk("t6.seq0", 32'(traceSeq), 32'd0);

        // Async reset in the middle of a drain
        for (int i = 0; i < 4; i++) begin
            commitOne(5'd12, 0);
            cycle("t6.refill");
        end
        idle(1);
        cycle("t6.drain1");
        #2;
        reset = 1'b0;
        #1;
        modelReset();
        checkAll("t6.areset");
        @(negedge clock);
        reset = 1'b1;
        commitOne(5'd13, 0);
        cycle("t6.post");
        chk("t6.postseq", 32'(traceSeq), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
